// File: rtl/segre_wb_arbiter_if.sv
// Result-channel and register-file write bus of the segre writeback arbiter.
// The arbiter takes the slave side; the pipelines/register file take the master side.
interface segre_wb_arbiter_if #(
    parameter int NUM_CH     = 3,
    parameter int NUM_WPORTS = 1,
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int ID_W       = 4
);
    logic [NUM_CH-1:0]            ch_valid_i;
    logic [NUM_CH-1:0]            ch_ready_o;
    logic [NUM_CH*REG_W-1:0]      ch_waddr_i;
    logic [NUM_CH*DATA_W-1:0]     ch_data_i;
    logic [NUM_CH*ID_W-1:0]       ch_id_i;
    logic [NUM_WPORTS-1:0]        rf_we_o;
    logic [NUM_WPORTS*REG_W-1:0]  rf_waddr_o;
    logic [NUM_WPORTS*DATA_W-1:0] rf_wdata_o;
    logic [NUM_WPORTS*ID_W-1:0]   rf_id_o;

    modport slave (
        input  ch_valid_i, ch_waddr_i, ch_data_i, ch_id_i,
        output ch_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_id_o
    );

    modport master (
        output ch_valid_i, ch_waddr_i, ch_data_i, ch_id_i,
        input  ch_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, rf_id_o
    );
endinterface

// File: rtl/segre_wb_arbiter.sv
// Writeback arbiter: per-channel result FIFOs drained round-robin, age-aware, into the RF.
// Define SEGRE_WB_BYPASS_EN to build the pending-result bypass lookup.
module segre_wb_arbiter #(
    parameter int NUM_CH     = 3,
    parameter int NUM_WPORTS = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int ID_W       = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    segre_wb_arbiter_if.slave     wb,
    input  logic [ID_W-1:0]       oldest_id_i,
    input  logic [2*REG_W-1:0]    byp_raddr_i,
    output logic [1:0]            byp_hit_o,
    output logic [2*DATA_W-1:0]   byp_data_o,
    output logic                  stall_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    function automatic logic [ID_W-1:0] age_f(input logic [ID_W-1:0] id,
                                              input logic [ID_W-1:0] ref_id);
        return id - ref_id;
    endfunction

    logic [REG_W-1:0]  mem_waddr_q [NUM_CH][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data_q  [NUM_CH][FIFO_DEPTH];
    logic [ID_W-1:0]   mem_id_q    [NUM_CH][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [CH_W-1:0]   rr_ptr_q;
    logic [CH_W-1:0]   rr_ptr_d;

    logic [NUM_CH-1:0] ready_s;
    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] push_s;
    logic [NUM_CH-1:0] head_valid_s;
    logic [NUM_CH-1:0] elig_s;
    logic [NUM_CH-1:0] grant_s;
    logic [REG_W-1:0]  head_waddr_s [NUM_CH];
    logic [DATA_W-1:0] head_data_s  [NUM_CH];
    logic [ID_W-1:0]   head_id_s    [NUM_CH];
    logic [ID_W-1:0]   head_age_s   [NUM_CH];

    logic [NUM_WPORTS-1:0]        rf_we_s;
    logic [NUM_WPORTS*REG_W-1:0]  rf_waddr_s;
    logic [NUM_WPORTS*DATA_W-1:0] rf_wdata_s;
    logic [NUM_WPORTS*ID_W-1:0]   rf_id_s;

    // Per-channel status, enqueue qualification and registered head view.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ready_s[c]      = (cnt_q[c] < CNT_W'(FIFO_DEPTH));
            full_s[c]       = (cnt_q[c] == CNT_W'(FIFO_DEPTH));
            push_s[c]       = wb.ch_valid_i[c] & ready_s[c] &
                              (wb.ch_waddr_i[c*REG_W +: REG_W] != {REG_W{1'b0}});
            head_valid_s[c] = (cnt_q[c] != {CNT_W{1'b0}});
            head_waddr_s[c] = mem_waddr_q[c][rd_ptr_q[c]];
            head_data_s[c]  = mem_data_q[c][rd_ptr_q[c]];
            head_id_s[c]    = mem_id_q[c][rd_ptr_q[c]];
            head_age_s[c]   = age_f(mem_id_q[c][rd_ptr_q[c]], oldest_id_i);
        end
    end

    // A head is held back while an older head targets the same register (WAW order).
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            elig_s[c] = head_valid_s[c];
            for (int j = 0; j < NUM_CH; j++) begin
                elig_s[c] = elig_s[c] & ~((j != c) && head_valid_s[j] &&
                            (head_waddr_s[j] == head_waddr_s[c]) &&
                            ((head_age_s[j] < head_age_s[c]) ||
                             ((head_age_s[j] == head_age_s[c]) && (j < c))));
            end
        end
    end

    // Round-robin grant scan from rr_ptr; the k-th grant drives write port k.
    always_comb begin
        int gcnt;
        int last;
        int idx;
        gcnt       = 0;
        last       = 0;
        grant_s    = {NUM_CH{1'b0}};
        rf_we_s    = {NUM_WPORTS{1'b0}};
        rf_waddr_s = {(NUM_WPORTS*REG_W){1'b0}};
        rf_wdata_s = {(NUM_WPORTS*DATA_W){1'b0}};
        rf_id_s    = {(NUM_WPORTS*ID_W){1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_CH;
            if (elig_s[idx] && (gcnt < NUM_WPORTS)) begin
                grant_s[idx]                       = 1'b1;
                rf_we_s[gcnt]                      = 1'b1;
                rf_waddr_s[gcnt*REG_W +: REG_W]    = head_waddr_s[idx];
                rf_wdata_s[gcnt*DATA_W +: DATA_W]  = head_data_s[idx];
                rf_id_s[gcnt*ID_W +: ID_W]         = head_id_s[idx];
                gcnt                               = gcnt + 1;
                last                               = idx;
            end else begin
                last = last;
            end
        end
        if (gcnt != 0) begin
            rr_ptr_d = CH_W'((last + 1) % NUM_CH);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // FIFO pointer and occupancy next state; simultaneous push and pop cancel.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(push_s[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(grant_s[c]);
            cnt_d[c]    = cnt_q[c] + CNT_W'(push_s[c]) - CNT_W'(grant_s[c]);
        end
    end

    // State registers and FIFO storage; reset flushes every pending result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= {CH_W{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr_q[c] <= {PTR_W{1'b0}};
                wr_ptr_q[c] <= {PTR_W{1'b0}};
                cnt_q[c]    <= {CNT_W{1'b0}};
                for (int s = 0; s < FIFO_DEPTH; s++) begin
                    mem_waddr_q[c][s] <= {REG_W{1'b0}};
                    mem_data_q[c][s]  <= {DATA_W{1'b0}};
                    mem_id_q[c][s]    <= {ID_W{1'b0}};
                end
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr_q[c] <= rd_ptr_d[c];
                wr_ptr_q[c] <= wr_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
                if (push_s[c]) begin
                    mem_waddr_q[c][wr_ptr_q[c]] <= wb.ch_waddr_i[c*REG_W +: REG_W];
                    mem_data_q[c][wr_ptr_q[c]]  <= wb.ch_data_i[c*DATA_W +: DATA_W];
                    mem_id_q[c][wr_ptr_q[c]]    <= wb.ch_id_i[c*ID_W +: ID_W];
                end
            end
        end
    end

`ifdef SEGRE_WB_BYPASS_EN
    logic [1:0]          byp_hit_s;
    logic [2*DATA_W-1:0] byp_data_s;

    // Youngest valid pending entry matching each decode source register.
    always_comb begin
        logic [REG_W-1:0] raddr;
        logic [ID_W-1:0]  best_age;
        logic [ID_W-1:0]  a;
        logic [PTR_W-1:0] off;
        logic             match;
        byp_hit_s  = 2'b00;
        byp_data_s = {(2*DATA_W){1'b0}};
        for (int p = 0; p < 2; p++) begin
            raddr    = byp_raddr_i[p*REG_W +: REG_W];
            best_age = {ID_W{1'b0}};
            for (int c = 0; c < NUM_CH; c++) begin
                for (int s = 0; s < FIFO_DEPTH; s++) begin
                    off   = PTR_W'(s) - rd_ptr_q[c];
                    a     = age_f(mem_id_q[c][s], oldest_id_i);
                    match = ({1'b0, off} < cnt_q[c]) && (raddr != {REG_W{1'b0}}) &&
                            (mem_waddr_q[c][s] == raddr);
                    if (match && (!byp_hit_s[p] || (a > best_age))) begin
                        byp_hit_s[p]                     = 1'b1;
                        best_age                         = a;
                        byp_data_s[p*DATA_W +: DATA_W]   = mem_data_q[c][s];
                    end else begin
                        best_age = best_age;
                    end
                end
            end
        end
    end

    assign byp_hit_o  = byp_hit_s;
    assign byp_data_o = byp_data_s;
`else
    logic unused_byp_s;
    assign unused_byp_s = ^byp_raddr_i;
    assign byp_hit_o    = 2'b00;
    assign byp_data_o   = {(2*DATA_W){1'b0}};
`endif

    assign wb.ch_ready_o = ready_s;
    assign wb.rf_we_o    = rf_we_s;
    assign wb.rf_waddr_o = rf_waddr_s;
    assign wb.rf_wdata_o = rf_wdata_s;
    assign wb.rf_id_o    = rf_id_s;
    assign stall_o       = |full_s;

    segre_wb_arbiter_chk #(.NUM_CH(NUM_CH)) u_chk (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (wb.ch_valid_i),
        .ready_i (ready_s)
    );
endmodule

// Protocol checker: upstream must not present a result to a channel that is not ready.
module segre_wb_arbiter_chk #(
    parameter int NUM_CH = 3
) (
    input logic              clk_i,
    input logic              rst_i,
    input logic [NUM_CH-1:0] valid_i,
    input logic [NUM_CH-1:0] ready_i
);
    // Valid-without-ready check outside reset.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert ((valid_i & ~ready_i) == {NUM_CH{1'b0}});
        end
    end
endmodule

// File: doc/segre_wb_arbiter.md
# segre_wb_arbiter

Parametrised writeback arbiter between the execution pipelines and the register file. Each of `NUM_CH` pipeline result channels feeds its own small FIFO, and a round-robin, age-aware arbiter drains up to `NUM_WPORTS` writes per cycle into the register file. Writeback collisions on a shared write port are therefore queued instead of forbidden. The block also exposes the pending, not-yet-written results to decode for bypassing.

## Interface
Parameters:
- `NUM_CH`, 3, number of result channels (EX, MEM, RVM, …).
- `NUM_WPORTS`, 1, register-file write ports; 1 ≤ `NUM_WPORTS` ≤ `NUM_CH`.
- `FIFO_DEPTH`, 4, entries per channel FIFO; power of two, ≥ 2.
- `DATA_W`, 32, result width.
- `REG_W`, 5, register address width.
- `ID_W`, 4, instruction-ID width (history-file pointer).

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `ch_valid_i`  in  `NUM_CH`  per-channel result valid.
- `ch_ready_o`  out  `NUM_CH`  per-channel FIFO can accept.
- `ch_waddr_i`  in  `NUM_CH*REG_W`  destination register per channel.
- `ch_data_i`  in  `NUM_CH*DATA_W`  result per channel.
- `ch_id_i`  in  `NUM_CH*ID_W`  instruction ID per channel.
- `oldest_id_i`  in  `ID_W`  ID of the oldest in-flight instruction; the age reference.
- `rf_we_o`  out  `NUM_WPORTS`  write enable per port.
- `rf_waddr_o`  out  `NUM_WPORTS*REG_W`  write address per port.
- `rf_wdata_o`  out  `NUM_WPORTS*DATA_W`  write data per port.
- `rf_id_o`  out  `NUM_WPORTS*ID_W`  ID of the written instruction, for completion.
- `byp_raddr_i`  in  `2*REG_W`  two decode source registers to look up.
- `byp_hit_o`  out  2  a pending entry matches the source register.
- `byp_data_o`  out  `2*DATA_W`  youngest matching pending data.
- `stall_o`  out  1  any channel FIFO is full.

## Operation
- **Enqueue.** Channel c enqueues on `ch_valid_i[c] & ch_ready_o[c]`.
  - Results with `waddr==0` are accepted and discarded; nothing is enqueued.
  - `ch_valid_i[c]` while `ch_ready_o[c]==0` is a protocol error (assertion). Upstream stalls on `stall_o`.
- **Ready.** `ch_ready_o[c] = (count[c] < FIFO_DEPTH)`. It ignores a same-cycle dequeue, which is conservative.
- **Age.** `age(id) = (id - oldest_id_i) mod 2^ID_W`. A smaller age is older.
- **Arbitration** runs each cycle over the non-empty FIFO heads.
  - Candidates are scanned in round-robin order starting at `rr_ptr`.
  - Up to `NUM_WPORTS` heads are granted. The k-th grant drives port k.
  - If two candidate heads share a `waddr`, only the older one is eligible this cycle. This preserves WAW order. Among three or more heads sharing a `waddr`, only the oldest is eligible.
  - A granted head is popped in the same cycle.
- **Pointer.** `rr_ptr` advances to (last granted channel + 1) mod `NUM_CH`, and is unchanged when there is no grant.
- **Port outputs.** Ungranted ports drive `rf_we_o=0` with address, data and ID all 0.
- **Counts.** Enqueue and dequeue in the same cycle on one FIFO leave `count` unchanged. Pointers wrap mod `FIFO_DEPTH`.
- **Status.** `stall_o = |(count[c]==FIFO_DEPTH)`.
- **Bypass lookup.** Covers all valid entries of all FIFOs, heads included.
  - `byp_raddr_i==0` never hits.
  - On multiple matches, the entry with the largest age (youngest) supplies `byp_data_o`.
  - On no match, `byp_hit_o=0` and `byp_data_o=0`.
- **Reset** (mid-operation included): all FIFOs are flushed and pending results dropped; `rr_ptr=0`.

## Timing
- Reset values: `ch_ready_o` all 1 (the FIFOs are empty), `rf_we_o`/`rf_waddr_o`/`rf_wdata_o`/`rf_id_o` 0, `byp_hit_o`/`byp_data_o` 0, `stall_o` 0.
- FIFO state is registered. Grant and `rf_*` outputs are combinational from the registered heads.
  - Minimum latency from enqueue in cycle N to `rf_we_o` in cycle N+1.
  - No same-cycle pass-through.
- An entry enqueued in cycle N is visible to the bypass lookup from N+1. It stops being visible in the cycle after its write (it is popped in the write cycle).
- Worst-case latency for a head under full contention is `ceil(NUM_CH/NUM_WPORTS)` cycles, excluding same-`waddr` ordering holds.

## Configuration
- `SEGRE_WB_BYPASS_EN` defined: the lookup logic is built, as described above.
- Undefined: no lookup logic. `byp_hit_o` is tied to 0, `byp_data_o` to 0, and `byp_raddr_i` is ignored. All ports are still present.

## Test plan
- **Single enqueue.** After reset, ch0 enqueues `waddr=5`, `data=0xA5`, `id=2` in cycle 1. Expect cycle 2: `rf_we_o[0]=1`, `waddr 5`, `data 0xA5`, `id 2`; cycle 3: `rf_we_o=0`.
- **Three-way collision** (`NUM_WPORTS=1`, `oldest_id_i=0`). All 3 channels enqueue distinct registers in the same cycle. Expect writes on 3 consecutive cycles in order ch0, ch1, ch2; next collision order ch0, ch1, ch2 again (`rr_ptr` back to 0).
- **WAW ordering.** ch0 `id=6 waddr=7 data=1` and ch2 `id=4 waddr=7 data=2` enqueue together, `oldest_id_i=3`. Expect the ch2 write first, then ch0; the register's final value is 1. Repeat with `oldest_id_i=14` and ids 15/1 (wrap): id 15 is written first.
- **Full/backpressure** (`FIFO_DEPTH=4`). Five back-to-back ch1 enqueues while ch0 holds priority. Expect `ch_ready_o[1]=0` and `stall_o=1` once count reaches 4; no entry lost or duplicated.
- **Bypass** (macro defined). Pending ch1 `waddr=9 data=0x11 id=1` and ch0 `waddr=9 data=0x22 id=3`, `oldest_id_i=0`, `byp_raddr_i[0]=9`. Expect `byp_hit_o[0]=1`, `data 0x22`. `byp_raddr_i=0` gives no hit. With the macro undefined, the hit is always 0.
- **Reset mid-operation.** Assert `rst_i` with 3 pending entries. Expect the next cycle `rf_we_o=0`, all ready, no writes afterwards.
